parity_batch_scheduler: RTL
===========================

# parity_batch_scheduler

Sequencer that runs the column-parity engine over a contiguous range of input file indices without host involvement per job. For each job it presents a file index, holds the engine's start for a fixed number of cycles, waits for the engine's finish edge, then advances to the next index. It sits between the host/top-level control and the existing parity engine's `start`/`file_index`/`finish` ports, and counts completed jobs.

## Interface
- `IDX_W`, 10: width of file index and job count.
- `START_CYCLES`, 3: cycles `engine_start` is held high per job (≥1).
- `TIMEOUT_CYCLES`, 4096: watchdog limit in WAIT; used only with `PARITY_SCHED_TIMEOUT_EN`.

- `clk` in 1: single clock; all logic rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `batch_start` in 1: one-cycle request; sampled only in IDLE.
- `first_index` in IDX_W: first file index; sampled with `batch_start`.
- `job_count` in IDX_W: number of jobs; sampled with `batch_start`.
- `abort` in 1: cancel the batch; wins over every other event.
- `engine_start` out 1: start to parity engine.
- `engine_file_index` out IDX_W: file index to parity engine.
- `engine_finish` in 1: finish from parity engine (level; may stay high between jobs).
- `busy` out 1: batch in progress.
- `done` out 1: one-cycle pulse at batch end (normal or aborted).
- `aborted` out 1: high with `done` when the batch ended via `abort`.
- `jobs_done` out IDX_W: jobs finished in the current/last batch.
- `timeout_err` out 1: one-cycle pulse per timed-out job.

## Operation
- States: IDLE, ISSUE, WAIT, NEXT, FIN.
- IDLE: `batch_start`=1 latches index and count, clears `jobs_done`. count≠0 → ISSUE. count=0 → FIN with no engine start.
- ISSUE: `engine_start`=1 for exactly START_CYCLES cycles, then WAIT.
- WAIT: completion is a 0→1 edge on registered `engine_finish`. A level already high on entry is ignored until it drops and rises again. On the edge: `jobs_done`+1, remaining−1, then NEXT.
- NEXT: remaining=0 → FIN; otherwise index+1 → ISSUE. Index is mod 2^IDX_W, so 1023+1 wraps to 0.
- FIN: `done`=1 for one cycle, `busy`=0, then IDLE.
- `abort` in any non-IDLE state: next cycle goes to FIN with `aborted`=1 and `engine_start`=0. `jobs_done` keeps jobs completed so far. An engine edge in the same cycle as `abort` is not counted.
- `batch_start` outside IDLE is ignored. `abort` in IDLE is ignored.
- `engine_file_index` is constant from ISSUE entry through WAIT.

## Timing
- All outputs are registered.
- Reset values: `engine_start`=0, `engine_file_index`=0, `busy`=0, `done`=0, `aborted`=0, `jobs_done`=0, `timeout_err`=0, state IDLE.
- `batch_start` at cycle T → `busy`=1 and `engine_start`=1 from T+1, index valid at T+1.
- `engine_start` high T+1..T+START_CYCLES.
- Finish edge seen at cycle F → next job's `engine_start` at F+2 (NEXT takes one cycle). On the last job, `done` at F+2.
- Count=0 → `done` at T+1, `busy` stays 0.
- Reset mid-batch: everything returns to reset values on the next edge. No `done` pulse.

## Configuration
- `PARITY_SCHED_TIMEOUT_EN` defined: a counter runs in WAIT. Reaching TIMEOUT_CYCLES pulses `timeout_err`, counts the job as attempted (remaining−1) but not done (`jobs_done` unchanged), then goes to NEXT.
- Not defined: WAIT waits indefinitely, `timeout_err` is tied 0, and no counter is synthesized.

## Structure
- Shared package `parity_sched_pkg`: state enum, `IDX_W` default constant, index typedef.
- One sub-module, `parity_sched_watchdog` (clear/enable/expire counter), instantiated only under the macro.

## Test plan
- first_index=0, job_count=3, engine model asserts finish 20 cycles after start falls → indices 0,1,2, each start 3 cycles wide; `done` once; `jobs_done`=3.
- job_count=0 → `done` one cycle after `batch_start`, `engine_start` never high, `jobs_done`=0.
- first_index=1022, job_count=3 → indices 1022, 1023, 0.
- `engine_finish` stuck high from the previous batch → no job counted until finish falls and rises again.
- `abort` during WAIT of the 2nd job of 4 → `done`=`aborted`=1 next cycle; `jobs_done`=1; no further `engine_start`.
- With macro, TIMEOUT_CYCLES=50, engine never finishes job 1 of 2 → `timeout_err` pulse after 50 WAIT cycles, job 2 issued, final `jobs_done`=1.

Source files
------------

// File: rtl/parity_sched_pkg.sv
// Shared types for the parity batch scheduler: FSM states, default index width, index type.
package parity_sched_pkg;

  localparam int IDX_W_DEF = 10;

  typedef logic [IDX_W_DEF-1:0] idx_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_NEXT,
    ST_FIN
  } state_e;

endpackage

// File: rtl/parity_batch_scheduler_if.sv
// Host/engine-side signal bundle of the parity batch scheduler; slave = scheduler, master = its environment.
interface parity_batch_scheduler_if #(
  parameter int IDX_W = parity_sched_pkg::IDX_W_DEF
);
  logic             batch_start;
  logic [IDX_W-1:0] first_index;
  logic [IDX_W-1:0] job_count;
  logic             abort;
  logic             engine_start;
  logic [IDX_W-1:0] engine_file_index;
  logic             engine_finish;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [IDX_W-1:0] jobs_done;
  logic             timeout_err;

  modport master (
    output batch_start, first_index, job_count, abort, engine_finish,
    input  engine_start, engine_file_index, busy, done, aborted, jobs_done, timeout_err
  );

  modport slave (
    input  batch_start, first_index, job_count, abort, engine_finish,
    output engine_start, engine_file_index, busy, done, aborted, jobs_done, timeout_err
  );
endinterface

// File: rtl/parity_sched_watchdog.sv
// Clear/enable/expire cycle counter guarding the scheduler's WAIT state (PARITY_SCHED_TIMEOUT_EN builds only).
// expire_o is asserted during the LIMIT-th consecutive enabled cycle.
`ifdef PARITY_SCHED_TIMEOUT_EN
module parity_sched_watchdog #(
  parameter int LIMIT = 4096
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  assign expire_o = en_i && (cnt_q == CW'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule
`endif

// File: rtl/parity_batch_scheduler.sv
// Runs the parity engine over a contiguous, wrapping range of file indices and counts finished jobs.
// Optional WAIT watchdog enabled by defining PARITY_SCHED_TIMEOUT_EN.
module parity_batch_scheduler
  import parity_sched_pkg::*;
#(
  parameter int IDX_W        = IDX_W_DEF,
  parameter int START_CYCLES = 3
`ifdef PARITY_SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input logic                     clk,
  input logic                     rst,
  parity_batch_scheduler_if.slave bus
);
  localparam int SC_W = $clog2(START_CYCLES + 1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] rem_q;
  logic [IDX_W-1:0] jobs_done_q;
  logic [SC_W-1:0]  start_cnt_q;
  logic             start_q;
  logic             busy_q;
  logic             done_q;
  logic             aborted_q;
  logic             timeout_err_q;
  logic             fin_q;
  logic             fin_prev_q;
  logic             fin_rise;
  logic             wdog_expire;

  // Only a fresh rise counts, so a finish level left over from the last job is ignored.
  assign fin_rise = fin_q & ~fin_prev_q;

`ifdef PARITY_SCHED_TIMEOUT_EN
  parity_sched_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (state_q != ST_WAIT),
    .en_i    (state_q == ST_WAIT),
    .expire_o(wdog_expire)
  );
`else
  assign wdog_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      rem_q         <= '0;
      jobs_done_q   <= '0;
      start_cnt_q   <= '0;
      start_q       <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      fin_q         <= 1'b0;
      fin_prev_q    <= 1'b0;
    end else begin
      fin_q         <= bus.engine_finish;
      fin_prev_q    <= fin_q;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      if (bus.abort && (state_q != ST_IDLE) && (state_q != ST_FIN)) begin
        state_q   <= ST_FIN;
        start_q   <= 1'b0;
        busy_q    <= 1'b0;
        done_q    <= 1'b1;
        aborted_q <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (bus.batch_start) begin
              idx_q       <= bus.first_index;
              rem_q       <= bus.job_count;
              jobs_done_q <= '0;
              if (bus.job_count != '0) begin
                state_q     <= ST_ISSUE;
                start_q     <= 1'b1;
                busy_q      <= 1'b1;
                start_cnt_q <= SC_W'(1);
              end else begin
                state_q <= ST_FIN;
                done_q  <= 1'b1;
              end
            end
          end
          ST_ISSUE: begin
            if (start_cnt_q == SC_W'(START_CYCLES)) begin
              state_q <= ST_WAIT;
              start_q <= 1'b0;
            end else begin
              start_cnt_q <= start_cnt_q + 1'b1;
            end
          end
          ST_WAIT: begin
            if (fin_rise) begin
              jobs_done_q <= jobs_done_q + 1'b1;
              rem_q       <= rem_q - 1'b1;
              state_q     <= ST_NEXT;
            end else if (wdog_expire) begin
              timeout_err_q <= 1'b1;
              rem_q         <= rem_q - 1'b1;
              state_q       <= ST_NEXT;
            end
          end
          ST_NEXT: begin
            if (rem_q == '0) begin
              state_q <= ST_FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q       <= idx_q + 1'b1;
              state_q     <= ST_ISSUE;
              start_q     <= 1'b1;
              start_cnt_q <= SC_W'(1);
            end
          end
          ST_FIN:  state_q <= ST_IDLE;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.engine_start      = start_q;
  assign bus.engine_file_index = idx_q;
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign bus.aborted           = aborted_q;
  assign bus.jobs_done         = jobs_done_q;
  assign bus.timeout_err       = timeout_err_q;

endmodule
